// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: latches a 5-bit BCD value (tens bit + ones nibble) and
// time-multiplexes it onto the two rightmost digits of a common-anode
// 4-digit 7-segment display. Each digit slot starts with a blanking gap
// to suppress ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (darkens a zero tens digit).
module bcd_seg7_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] BCD,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    shadow;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;
  logic          fd_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Shadow copy of the converter output, refreshed whenever load is high.
  always_ff @(posedge clk) begin
    if (rst)       shadow <= 5'b0;
    else if (load) shadow <= BCD;
  end

  // State and in-state cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: advance when the current state's length is used up.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    if (cnt == (((state == BLANK0) || (state == BLANK1)) ? BLANK_LAST : SHOW_LAST)) begin
      cnt_nxt = '0;
      case (state)
        BLANK0:  state_nxt = SHOW0;
        SHOW0:   state_nxt = BLANK1;
        BLANK1:  state_nxt = SHOW1;
        default: state_nxt = BLANK0;
      endcase
    end
  end

  // Next display outputs from current state and shadow value.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    fd_nxt  = (state == SHOW1) && (cnt == SHOW_LAST);
    case (state)
      SHOW0: begin
        an_nxt  = 4'b1110;
        seg_nxt = decode(shadow[3:0]);
      end
      SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (shadow[4]) begin
          an_nxt  = 4'b1101;
          seg_nxt = decode({3'b0, shadow[4]});
        end
`else
        an_nxt  = 4'b1101;
        seg_nxt = decode({3'b0, shadow[4]});
`endif
      end
      default: ;
    endcase
  end

  // Registered outputs; one cycle behind the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= fd_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan (REFRESH_DIV=8, BLANK_CYCLES=2).
// An independent frame-position model predicts the outputs for each edge;
// predictions are queued when inputs are driven and checked after the edge.
module tb_bcd_seg7_scan;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 2 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] bcd = 5'b0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_done;

  int n_chk = 0;
  int n_pass = 0;

  int         m_phase = 0;
  logic [4:0] m_shadow = 5'b0;
  logic [12:0] sb_q[$];

  bcd_seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .BCD(bcd), .load(load),
    .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d > 4'd9) ? 7'b0111111 : tbl[d];
  endfunction

  // {an, seg, dp, frame_done} expected after an edge, given the frame
  // position and shadow value held just before that edge.
  function automatic logic [12:0] predict(input int ph, input logic [4:0] sh);
    logic [3:0] a;
    logic [6:0] s;
    a = 4'b1111;
    s = 7'b1111111;
    if (ph >= BC && ph < RD) begin
      a = 4'b1110;
      s = seg_of(sh[3:0]);
    end else if (ph >= RD + BC) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (sh[4]) begin
        a = 4'b1101;
        s = seg_of({3'b0, sh[4]});
      end
`else
      a = 4'b1101;
      s = seg_of({3'b0, sh[4]});
`endif
    end
    return {a, s, 1'b1, (ph == FRAME - 1)};
  endfunction

  // One clock: drive inputs, queue the prediction, advance model, check.
  task automatic step(input logic r, input logic ld, input logic [4:0] v);
    logic [12:0] e;
    logic [12:0] got;
    @(negedge clk);
    rst = r; load = ld; bcd = v;
    if (r) sb_q.push_back({4'b1111, 7'b1111111, 1'b1, 1'b0});
    else   sb_q.push_back(predict(m_phase, m_shadow));
    if (r) begin
      m_phase = 0;
      m_shadow = 5'b0;
    end else begin
      m_phase = (m_phase + 1) % FRAME;
      if (ld) m_shadow = v;
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got = {an, seg, dp, frame_done};
    chk("an", 32'(got[12:9]), 32'(e[12:9]));
    chk("seg", 32'(got[8:2]), 32'(e[8:2]));
    chk("dp", 32'(got[1]), 32'(e[1]));
    chk("frame_done", 32'(got[0]), 32'(e[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'b0);
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < FRAME && m_phase != p; i++) step(1'b0, 1'b0, 5'b0);
  endtask

  initial begin
    logic [4:0] v;
    int fd_cnt;
    // reset held three cycles, then two idle frames of shadow=0
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'b0);
    idle(2 * FRAME + 2);
    // 17 : ones 7, tens 1
    to_phase(0);
    step(1'b0, 1'b1, 5'b10111);
    idle(FRAME);
    // converter sweep for bin 0..15, one value per frame
    for (int b = 0; b < 16; b++) begin
      v = (b < 10) ? 5'(b) : {1'b1, 4'(b - 10)};
      to_phase(0);
      step(1'b0, 1'b1, v);
      idle(FRAME - 1);
    end
    // change value in the middle of SHOW0
    to_phase(4);
    step(1'b0, 1'b1, 5'b00011);
    idle(3);
    step(1'b0, 1'b1, 5'b10100);
    idle(FRAME);
    // illegal ones digit
    step(1'b0, 1'b1, 5'b01100);
    idle(FRAME + 2);
    // zero tens digit; count frame_done pulses over four frames
    step(1'b0, 1'b1, 5'b00101);
    fd_cnt = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step(1'b0, 1'b0, 5'b0);
      if (frame_done) fd_cnt++;
    end
    chk("fd_count", 32'(fd_cnt), 32'd4);
    // reset during SHOW1 together with load
    step(1'b0, 1'b1, 5'b10010);
    to_phase(12);
    step(1'b1, 1'b1, 5'b10011);
    idle(FRAME + 4);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
